// File: rtl/request_queue_ctrl_pkg.sv
// Shared types for the request queue between trace parser and scheduler.
// Holds opcode, parser bundle, queue entry layout and default sizes.
package request_queue_ctrl_pkg;

    localparam int DEF_QUEUE_DEPTH = 16;
    localparam int ADDRESS_WIDTH   = 33;
    localparam int TIME_WIDTH      = 32;

    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        IFETCH = 2'd2,
        NOP    = 2'd3
    } parsed_op_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [TIME_WIDTH-1:0]    time_cpu;
    } parser_out_struct_t;

    typedef struct packed {
        parsed_op_t               opcode;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [TIME_WIDTH-1:0]    arr_time;
    } queue_entry_t;

    function automatic bit is_pow2(int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/request_queue_ctrl_if.sv
// Parser-side admission and scheduler-side dequeue signals of the queue.
// slave is the queue controller, master is whoever drives it.
interface request_queue_ctrl_if
    import request_queue_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic                     in_valid;
    parsed_op_t               in_opcode;
    logic [ADDRESS_WIDTH-1:0] in_address;
    logic [TIME_WIDTH-1:0]    in_time;
    logic                     queue_full;
    logic                     pending_request;
    logic                     deq_valid;
    logic                     deq_ready;
    queue_entry_t             deq_entry;
    logic [TIME_WIDTH-1:0]    sim_time;
    logic [CW-1:0]            occupancy;

    modport slave (
        input  in_valid, in_opcode, in_address, in_time,
        input  deq_ready,
        output queue_full, pending_request,
        output deq_valid, deq_entry,
        output sim_time, occupancy
    );

    modport master (
        output in_valid, in_opcode, in_address, in_time,
        output deq_ready,
        input  queue_full, pending_request,
        input  deq_valid, deq_entry,
        input  sim_time, occupancy
    );

endinterface

// File: rtl/request_queue_ctrl_fifo_mem.sv
// Entry storage for the request queue.
// Synchronous write, asynchronous read of the head slot.
module req_fifo_mem
    import request_queue_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  queue_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output queue_entry_t rdata
);

    queue_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/request_queue_ctrl.sv
// Admission control, time base and in-order queue between parser
// and DRAM scheduler; storage lives in req_fifo_mem.
module request_queue_ctrl
    import request_queue_ctrl_pkg::*;
#(
    parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
    input logic                  clk,
    input logic                  rst_n,
    request_queue_ctrl_if.slave  bus
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    if (!is_pow2(QUEUE_DEPTH)) begin : g_depth_chk
        $error("QUEUE_DEPTH must be a power of 2 and >= 2");
    end

    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic [TIME_WIDTH-1:0] sim_time_q, sim_time_d;

    logic         in_real;
    logic         full;
    logic         empty;
    logic         accept;
    logic         pop;
    queue_entry_t wr_entry;
    queue_entry_t head_entry;

    always_comb begin
        in_real = bus.in_valid && (bus.in_opcode != NOP);
        full    = (count_q == CW'(QUEUE_DEPTH));
        empty   = (count_q == '0);
        accept  = in_real && !full
                  && (bus.in_time <= sim_time_q);
        pop     = !empty && bus.deq_ready;

        head_d  = head_q;
        tail_d  = tail_q;
        if (accept) begin
            tail_d = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(accept) - CW'(pop);

        // Skip idle time only while nothing is waiting to be served
        if (empty && in_real && (bus.in_time > sim_time_q)) begin
            sim_time_d = bus.in_time;
        end else if (sim_time_q != '1) begin
            sim_time_d = sim_time_q + TIME_WIDTH'(1);
        end else begin
            sim_time_d = sim_time_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            sim_time_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            sim_time_q <= sim_time_d;
        end
    end

    always_comb begin
        wr_entry          = '0;
        wr_entry.opcode   = bus.in_opcode;
        wr_entry.address  = bus.in_address;
        wr_entry.arr_time = bus.in_time;
    end

    req_fifo_mem #(
        .DEPTH (QUEUE_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (head_entry)
    );

    // Stale payload is masked so an empty queue always shows zero
    assign bus.deq_entry       = empty ? '0 : head_entry;
    assign bus.deq_valid       = !empty;
    assign bus.queue_full      = full;
    assign bus.pending_request = in_real && !accept;
    assign bus.sim_time        = sim_time_q;
    assign bus.occupancy       = count_q;

endmodule

// File: tb/tb_request_queue_ctrl.sv
// Directed plus randomized bench for request_queue_ctrl against a
// queue-based reference model of admission, ordering and time base.
module tb_request_queue_ctrl;
    import request_queue_ctrl_pkg::*;

    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    request_queue_ctrl_if #(.QUEUE_DEPTH(D)) bus();

    request_queue_ctrl #(
        .QUEUE_DEPTH (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    queue_entry_t mq[$];
    logic [31:0]  mtime = '0;
    int compared   = 0;
    int mismatched = 0;
    int popped     = 0;
    bit last_acc   = 0;
    bit last_pend  = 0;
    bit rnd_ready  = 0;

    task automatic chk(string tag, logic [127:0] obs,
                       logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit m_real();
        return bus.in_valid && (bus.in_opcode != NOP);
    endfunction

    function automatic bit m_accept();
        return m_real() && (mq.size() < D)
               && (bus.in_time <= mtime);
    endfunction

    task automatic check_all();
        queue_entry_t e;
        if (!rst_n) return;
        e = '0;
        if (mq.size() != 0) e = mq[0];
        chk("sim_time", bus.sim_time, mtime);
        chk("occupancy", bus.occupancy, mq.size());
        chk("queue_full", bus.queue_full, mq.size() == D);
        chk("deq_valid", bus.deq_valid, mq.size() != 0);
        chk("pending", bus.pending_request,
            m_real() && !m_accept());
        chk("deq_entry", bus.deq_entry, e);
    endtask

    task automatic model_edge();
        bit acc, pop, skip;
        queue_entry_t e;
        if (!rst_n) begin
            mq.delete();
            mtime    = '0;
            last_acc = 0;
            return;
        end
        acc  = m_accept();
        pop  = (mq.size() != 0) && bus.deq_ready;
        skip = (mq.size() == 0) && m_real()
               && (bus.in_time > mtime);
        if (pop) begin
            void'(mq.pop_front());
            popped++;
        end
        if (acc) begin
            e.opcode   = bus.in_opcode;
            e.address  = bus.in_address;
            e.arr_time = bus.in_time;
            mq.push_back(e);
        end
        if (skip) mtime = bus.in_time;
        else if (mtime != 32'hFFFF_FFFF) mtime = mtime + 1;
        last_acc = acc;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rnd_ready) bus.deq_ready = 1'($urandom_range(0, 1));
        #1;
        check_all();
        last_pend = bus.pending_request;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send_op(parsed_op_t op, logic [32:0] a,
                           logic [31:0] t);
        bus.in_opcode  = op;
        bus.in_address = a;
        bus.in_time    = t;
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("send_timeout", last_acc, 1);
        bus.in_valid  = 1'b0;
        bus.in_opcode = NOP;
    endtask

    task automatic drain();
        bus.deq_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0) break;
            cycle();
        end
        if (mq.size() != 0) chk("drain_timeout", mq.size(), 0);
        bus.deq_ready = 1'b0;
    endtask

    initial begin
        queue_entry_t exp_e;
        logic [63:0]  rnd;
        logic [31:0]  t;
        int           np;

        bus.in_valid   = 1'b0;
        bus.in_opcode  = NOP;
        bus.in_address = '0;
        bus.in_time    = '0;
        bus.deq_ready  = 1'b0;

        rst_n = 1'b0;
        cycle();
        cycle();

        // Test 1: reset state, then time skip and admission
        rst_n = 1'b1;
        bus.in_opcode  = READ;
        bus.in_address = 33'h1_0000_0040;
        bus.in_time    = 32'd5;
        bus.in_valid   = 1'b1;
        #1;
        chk("rst_sim_time", bus.sim_time, 0);
        chk("rst_occupancy", bus.occupancy, 0);
        chk("rst_deq_valid", bus.deq_valid, 0);
        chk("rst_queue_full", bus.queue_full, 0);
        chk("rst_deq_entry", bus.deq_entry, 0);
        cycle();
        chk("t1_skip_time", bus.sim_time, 5);
        chk("t1_deq_valid_early", bus.deq_valid, 0);
        cycle();
        bus.in_valid = 1'b0;
        bus.in_opcode = NOP;
        chk("t1_deq_valid", bus.deq_valid, 1);
        chk("t1_head_time", bus.deq_entry.arr_time, 5);
        chk("t1_head_addr", bus.deq_entry.address,
            33'h1_0000_0040);

        // Test 2: future op with non-empty queue waits, no skip
        bus.in_opcode  = WRITE;
        bus.in_address = 33'h0_0000_1230;
        bus.in_time    = mtime + 3;
        bus.in_valid   = 1'b1;
        np = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_pend) np++;
            if (last_acc) break;
        end
        bus.in_valid  = 1'b0;
        bus.in_opcode = NOP;
        chk("t2_pending_cycles", np, 3);
        chk("t2_occupancy", bus.occupancy, 2);

        // Test 3: fill to full, blocked 17th, admitted after pop
        drain();
        for (int i = 0; i < D; i++) begin
            send_op(parsed_op_t'(i % 3), 33'(i * 64), 32'd0);
        end
        chk("t3_occupancy", bus.occupancy, D);
        chk("t3_queue_full", bus.queue_full, 1);
        bus.in_opcode  = READ;
        bus.in_address = 33'h1_FFFF_FFC0;
        bus.in_time    = 32'd0;
        bus.in_valid   = 1'b1;
        cycle();
        chk("t3_17th_pending", last_pend, 1);
        bus.deq_ready = 1'b1;
        cycle();
        chk("t3_pop_cycle_pending", last_pend, 1);
        bus.deq_ready = 1'b0;
        cycle();
        chk("t3_admit_pending", last_pend, 0);
        bus.in_valid  = 1'b0;
        bus.in_opcode = NOP;
        chk("t3_refull", bus.occupancy, D);
        drain();

        // Test 4: random fill/drain with wrap-around
        popped    = 0;
        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 7 == 0) begin
                bus.in_valid  = 1'b1;
                bus.in_opcode = NOP;
                cycle();
                bus.in_valid  = 1'b0;
            end
            rnd = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1)
                t = mtime + 32'($urandom_range(0, 3));
            else if (mtime > 3)
                t = mtime - 32'($urandom_range(0, 3));
            else
                t = 32'd0;
            send_op(parsed_op_t'($urandom_range(0, 2)),
                    rnd[32:0], t);
        end
        rnd_ready = 0;
        drain();
        chk("t4_popped", popped, 40);
        chk("t4_empty", bus.occupancy, 0);

        // Test 5: reset with entries queued
        for (int i = 0; i < 5; i++) begin
            send_op(WRITE, 33'(i), 32'd0);
        end
        chk("t5_filled", bus.occupancy, 5);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("t5_occupancy", bus.occupancy, 0);
        chk("t5_deq_valid", bus.deq_valid, 0);
        chk("t5_sim_time", bus.sim_time, 0);

        // Test 6: NOP ignored, pop on empty ignored
        bus.in_valid  = 1'b1;
        bus.in_opcode = NOP;
        bus.in_time   = 32'd100;
        cycle();
        chk("t6_nop_pending", last_pend, 0);
        chk("t6_nop_occupancy", bus.occupancy, 0);
        chk("t6_no_skip", bus.sim_time, 1);
        bus.in_valid  = 1'b0;
        bus.deq_ready = 1'b1;
        cycle();
        cycle();
        chk("t6_empty_pop_occ", bus.occupancy, 0);
        chk("t6_empty_pop_valid", bus.deq_valid, 0);
        bus.deq_ready = 1'b0;
        send_op(IFETCH, 33'h0_ABCD_0000, mtime);
        exp_e.opcode   = IFETCH;
        exp_e.address  = 33'h0_ABCD_0000;
        exp_e.arr_time = 32'd3;
        chk("t6_entry", bus.deq_entry, exp_e);
        chk("t6_occupancy", bus.occupancy, 1);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
